datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Multi-cycle control FSM for the ARM-subset datapath: IR, MAR, MDR, status register, shifter/sign-ext,
//  condition tester. Sequences fetch/decode/execute and drives every load enable, mux select, ALU opcode
//  and the MFA/MOC memory handshake. Sits beside the datapath top; consumes IR contents and cond_test result.
// PARAMETERS
//  MOC_TIMEOUT  16  max cycles a memory state waits for MOC before entering ERROR (>=2)
// PORTS
//  CLK         in   1   clock, all state changes on rising edge
//  CLR         in   1   reset, asynchronous, active-low
//  IR          in   32  current instruction register contents
//  COND        in   1   cond_test result for IR[31:28] against current NZCV
//  MOC         in   1   memory operation complete, sampled on rising CLK
//  IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE  out 1 each  load enables to IR, MAR, MDR, status reg, register file
//  MFA         out  1   memory function active (request)
//  RW          out  1   1=read, 0=write
//  A_SEL       out  2   ALU A: 00 Rn, 01 PC(R15), 10 rsvd, 11 zero
//  B_SEL       out  2   ALU B: 00 shifter out, 01 MDR, 10 const 4, 11 zero
//  RF_DST_SEL  out  2   RF write dest: 00 Rd=IR[15:12], 01 R14, 10 R15
//  MDR_SEL     out  1   MDR source: 0 memory data, 1 RF Rd read port
//  ALU_OP      out  4   ARM DP opcode encoding (0100 ADD, 0010 SUB, ...)
//  STATE       out  4   current state encoding (debug/verification)
//  MEM_ERR     out  1   sticky memory-timeout flag
// BEHAVIOUR
//  - State reg async-cleared on CLR=0; outputs are combinational from state, IR, MOC (Moore except MOC-gated LEs).
//  - Reset (CLR=0, any time incl. mid-transfer): STATE=RESET(0); all LEs=0, MFA=0, RW=1, selects=0,
//    ALU_OP=0000, MEM_ERR=0, timeout counter=0. First rising edge with CLR=1 -> FETCH_A.
//  - Defaults in every state unless listed: LEs=0, MFA=0, RW=1, selects=00, ALU_OP=0100.
//  - States/encodings/transitions:
//    RESET(0) -> FETCH_A.
//    FETCH_A(1): A=PC,B=zero,ADD,MAR_LE=1 -> FETCH_M.
//    FETCH_M(2): MFA=1,RW=1,IR_LE=MOC; MOC -> FETCH_PC, else hold.
//    FETCH_PC(3): A=PC,B=const4,ADD,DST=R15,RF_LE=1 -> DECODE.
//    DECODE(4): no LE. COND=0 -> FETCH_A. Else IR[27:25]: 000/001 -> DP; 010/011 -> LS_ADDR;
//      101 -> IR[24]? BL_LINK : BR_PC; other -> FETCH_A (treated as NOP).
//    DP(5): A=Rn,B=shifter,ALU_OP=IR[24:21],DST=Rd; SR_LE=IR[20]; RF_LE=0 for opcodes 1000-1011
//      (TST/TEQ/CMP/CMN), else 1 -> FETCH_A.
//    LS_ADDR(6): A=Rn,B=shifter,ALU_OP=IR[23]?0100:0010,MAR_LE=1 -> IR[20]? LD_MEM : ST_MDR.
//    ST_MDR(7): MDR_SEL=1,MDR_LE=1 -> ST_MEM.
//    ST_MEM(8): MFA=1,RW=0; MOC -> FETCH_A, else hold.
//    LD_MEM(9): MFA=1,RW=1,MDR_SEL=0,MDR_LE=MOC; MOC -> LD_WB, else hold.
//    LD_WB(10): A=zero,B=MDR,ADD,DST=Rd,RF_LE=1 -> FETCH_A.
//    BL_LINK(11): A=PC,B=zero,ADD,DST=R14,RF_LE=1 -> BR_PC.
//    BR_PC(12): A=PC,B=shifter,ADD,DST=R15,RF_LE=1 -> FETCH_A.
//    ERROR(15): all LEs=0,MFA=0,MEM_ERR=1; hold until CLR=0.
//  - Timeout: counter clears on entry to FETCH_M/ST_MEM/LD_MEM; increments each cycle there with MOC=0;
//    MOC=0 when counter==MOC_TIMEOUT-1 -> ERROR. MOC=1 on that same cycle wins (normal transition).
//  - MFA held continuously through a wait; deasserts the cycle after MOC is sampled.
//  - Unused encodings 13,14 -> RESET on next edge.
// TESTING
//  1. CLR=0 while in LD_MEM with MFA=1 -> STATE=0, MFA=0, all LEs=0 before next edge; release -> STATE=1 next edge.
//  2. IR=32'hE0912003 (ADDS R2,R1,R3), COND=1, MOC on 1st FETCH_M cycle -> STATE 1,2,3,4,5,1; in DP ALU_OP=0100, RF_LE=1, SR_LE=1.
//  3. IR=32'hE1510002 (CMP R1,R2) -> DP: ALU_OP=1010, RF_LE=0, SR_LE=1.
//  4. Any IR with COND=0 at DECODE -> STATE 4->1, no LE asserted in DECODE.
//  5. IR=32'hE5912004 (LDR), MOC after 3 waits -> LD_MEM held 4 cycles, MDR_LE=1 only on MOC cycle; LD_WB RF_LE=1, DST=00.
//  6. IR=32'hEB000010 (BL) -> BL_LINK DST=01, BR_PC DST=10 B=00; separately MOC held 0 in FETCH_M -> STATE=15 after 16 cycles, MEM_ERR=1.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
// Bundle between the multi-cycle control sequencer and the ARM-subset datapath.
//   master : the sequencer. It consumes IR/COND/MOC and drives every load
//            enable, mux select, ALU opcode, the MFA/RW memory request and the
//            debug STATE / MEM_ERR status.
//   slave  : the datapath side. It drives IR/COND/MOC and consumes the controls.
// Signals:
//   IR[31:0]      current instruction register contents
//   COND          condition test result for IR[31:28] against NZCV
//   MOC           memory operation complete
//   IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE   load enables
//   MFA, RW       memory request, 1=read 0=write
//   A_SEL, B_SEL, RF_DST_SEL, MDR_SEL, ALU_OP   datapath steering
//   STATE[3:0]    current sequencer state encoding
//   MEM_ERR       sticky memory-timeout flag
// -----------------------------------------------------------------------------
interface datapath_sequencer_if;
    logic [31:0] IR;
    logic        COND;
    logic        MOC;
    logic        IR_LE;
    logic        MAR_LE;
    logic        MDR_LE;
    logic        SR_LE;
    logic        RF_LE;
    logic        MFA;
    logic        RW;
    logic [1:0]  A_SEL;
    logic [1:0]  B_SEL;
    logic [1:0]  RF_DST_SEL;
    logic        MDR_SEL;
    logic [3:0]  ALU_OP;
    logic [3:0]  STATE;
    logic        MEM_ERR;

    modport master (
        input  IR, COND, MOC,
        output IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE, MFA, RW,
               A_SEL, B_SEL, RF_DST_SEL, MDR_SEL, ALU_OP, STATE, MEM_ERR
    );

    modport slave (
        output IR, COND, MOC,
        input  IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE, MFA, RW,
               A_SEL, B_SEL, RF_DST_SEL, MDR_SEL, ALU_OP, STATE, MEM_ERR
    );
endinterface

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Multi-cycle fetch/decode/execute control FSM for the ARM-subset datapath.
// Ports:
//   CLK   rising-edge clock
//   CLR   asynchronous active-low reset
//   bus   datapath_sequencer_if.master (IR/COND/MOC in, all controls out)
// Parameter:
//   MOC_TIMEOUT  cycles a memory state may wait for MOC before ERROR (>=2)
// Controls are decoded from the state register, IR and MOC so that a memory
// wait can load IR/MDR in the very cycle MOC arrives. MEM_ERR is registered.
// -----------------------------------------------------------------------------
module datapath_sequencer #(
    parameter int MOC_TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 CLR,
    datapath_sequencer_if.master bus
);

    localparam int CW = $clog2(MOC_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH_A  = 4'd1,
        S_FETCH_M  = 4'd2,
        S_FETCH_PC = 4'd3,
        S_DECODE   = 4'd4,
        S_DP       = 4'd5,
        S_LS_ADDR  = 4'd6,
        S_ST_MDR   = 4'd7,
        S_ST_MEM   = 4'd8,
        S_LD_MEM   = 4'd9,
        S_LD_WB    = 4'd10,
        S_BL_LINK  = 4'd11,
        S_BR_PC    = 4'd12,
        S_ERROR    = 4'd15
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   wait_cnt_q;
    logic            mem_err_q;
    logic            in_wait_s;
    logic            timeout_s;

    // Memory-wait qualification and timeout detection.
    always_comb begin
        in_wait_s = (state_q == S_FETCH_M) || (state_q == S_ST_MEM) || (state_q == S_LD_MEM);
        timeout_s = in_wait_s && !bus.MOC && (wait_cnt_q == CW'(MOC_TIMEOUT - 1));
    end

    // State register, wait counter and sticky error flag.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q    <= S_RESET;
            wait_cnt_q <= {CW{1'b0}};
            mem_err_q  <= 1'b0;
        end else begin
            // Counter is zero whenever a wait state is entered because every
            // non-waiting cycle (and every MOC cycle) clears it.
            if (in_wait_s && !bus.MOC) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
            end else begin
                wait_cnt_q <= {CW{1'b0}};
            end

            if (timeout_s) begin
                state_q   <= S_ERROR;
                mem_err_q <= 1'b1;
            end else begin
                case (state_q)
                    S_RESET:    state_q <= S_FETCH_A;
                    S_FETCH_A:  state_q <= S_FETCH_M;
                    S_FETCH_M:  state_q <= bus.MOC ? S_FETCH_PC : S_FETCH_M;
                    S_FETCH_PC: state_q <= S_DECODE;
                    S_DECODE: begin
                        if (!bus.COND) begin
                            state_q <= S_FETCH_A;
                        end else begin
                            case (bus.IR[27:25])
                                3'b000, 3'b001: state_q <= S_DP;
                                3'b010, 3'b011: state_q <= S_LS_ADDR;
                                3'b101:         state_q <= bus.IR[24] ? S_BL_LINK : S_BR_PC;
                                default:        state_q <= S_FETCH_A;
                            endcase
                        end
                    end
                    S_DP:       state_q <= S_FETCH_A;
                    S_LS_ADDR:  state_q <= bus.IR[20] ? S_LD_MEM : S_ST_MDR;
                    S_ST_MDR:   state_q <= S_ST_MEM;
                    S_ST_MEM:   state_q <= bus.MOC ? S_FETCH_A : S_ST_MEM;
                    S_LD_MEM:   state_q <= bus.MOC ? S_LD_WB : S_LD_MEM;
                    S_LD_WB:    state_q <= S_FETCH_A;
                    S_BL_LINK:  state_q <= S_BR_PC;
                    S_BR_PC:    state_q <= S_FETCH_A;
                    S_ERROR:    state_q <= S_ERROR;
                    default:    state_q <= S_RESET;
                endcase
            end
        end
    end

    // Control decode from current state, IR and MOC.
    always_comb begin
        bus.IR_LE      = 1'b0;
        bus.MAR_LE     = 1'b0;
        bus.MDR_LE     = 1'b0;
        bus.SR_LE      = 1'b0;
        bus.RF_LE      = 1'b0;
        bus.MFA        = 1'b0;
        bus.RW         = 1'b1;
        bus.A_SEL      = 2'b00;
        bus.B_SEL      = 2'b00;
        bus.RF_DST_SEL = 2'b00;
        bus.MDR_SEL    = 1'b0;
        bus.ALU_OP     = 4'b0100;
        bus.STATE      = state_q;
        bus.MEM_ERR    = mem_err_q;

        case (state_q)
            S_RESET: begin
                bus.ALU_OP = 4'b0000;
            end
            S_FETCH_A: begin
                bus.A_SEL  = 2'b01;
                bus.B_SEL  = 2'b11;
                bus.MAR_LE = 1'b1;
            end
            S_FETCH_M: begin
                bus.MFA   = 1'b1;
                bus.IR_LE = bus.MOC;
            end
            S_FETCH_PC: begin
                bus.A_SEL      = 2'b01;
                bus.B_SEL      = 2'b10;
                bus.RF_DST_SEL = 2'b10;
                bus.RF_LE      = 1'b1;
            end
            S_DP: begin
                bus.ALU_OP = bus.IR[24:21];
                bus.SR_LE  = bus.IR[20];
                // TST/TEQ/CMP/CMN (10xx) only update flags.
                bus.RF_LE  = (bus.IR[24:23] != 2'b10);
            end
            S_LS_ADDR: begin
                bus.ALU_OP = bus.IR[23] ? 4'b0100 : 4'b0010;
                bus.MAR_LE = 1'b1;
            end
            S_ST_MDR: begin
                bus.MDR_SEL = 1'b1;
                bus.MDR_LE  = 1'b1;
            end
            S_ST_MEM: begin
                bus.MFA = 1'b1;
                bus.RW  = 1'b0;
            end
            S_LD_MEM: begin
                bus.MFA    = 1'b1;
                bus.MDR_LE = bus.MOC;
            end
            S_LD_WB: begin
                bus.A_SEL = 2'b11;
                bus.B_SEL = 2'b01;
                bus.RF_LE = 1'b1;
            end
            S_BL_LINK: begin
                bus.A_SEL      = 2'b01;
                bus.B_SEL      = 2'b11;
                bus.RF_DST_SEL = 2'b01;
                bus.RF_LE      = 1'b1;
            end
            S_BR_PC: begin
                bus.A_SEL      = 2'b01;
                bus.RF_DST_SEL = 2'b10;
                bus.RF_LE      = 1'b1;
            end
            default: begin
                bus.ALU_OP = 4'b0100;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
// Builds, per instruction, the expected cycle-by-cycle control trace from the
// instruction class, COND and the MOC latencies chosen for it, then replays the
// trace open-loop (IR/COND/MOC come from the trace) and compares every cycle.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

    localparam int TO = 16;

    logic CLK = 1'b0;
    logic CLR = 1'b0;

    datapath_sequencer_if bus();

    datapath_sequencer #(.MOC_TIMEOUT(TO)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_le, mar_le, mdr_le, sr_le, rf_le, mfa, rw;
        logic [1:0] a, b, dst;
        logic       msel;
        logic [3:0] op;
        logic       err;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic        moc;
        logic [31:0] ir;
        logic        cond;
    } stim_t;

    stim_t q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    endtask

    function automatic exp_t dflt(input logic [3:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        e.rw = 1'b1;
        e.op = 4'b0100;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t e;
        e.st = bus.STATE;     e.ir_le = bus.IR_LE;   e.mar_le = bus.MAR_LE;
        e.mdr_le = bus.MDR_LE; e.sr_le = bus.SR_LE;  e.rf_le = bus.RF_LE;
        e.mfa = bus.MFA;      e.rw = bus.RW;         e.a = bus.A_SEL;
        e.b = bus.B_SEL;      e.dst = bus.RF_DST_SEL; e.msel = bus.MDR_SEL;
        e.op = bus.ALU_OP;    e.err = bus.MEM_ERR;
        return e;
    endfunction

    task automatic push(input exp_t e, input logic moc, input logic [31:0] ir, input logic cond);
        stim_t s;
        s.e = e; s.moc = moc; s.ir = ir; s.cond = cond;
        q.push_back(s);
    endtask

    // gate: 0 nothing follows MOC, 1 IR load follows MOC, 2 MDR load follows MOC
    task automatic push_wait(input exp_t base, input int w, input int gate,
                             input logic [31:0] ir, input logic cond, output bit to);
        exp_t e;
        if (w >= TO) begin
            for (int i = 0; i < TO; i++) push(base, 1'b0, ir, cond);
            e = dflt(4'd15);
            e.err = 1'b1;
            for (int i = 0; i < 3; i++) push(e, 1'($urandom_range(0, 1)), ir, cond);
            to = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) push(base, 1'b0, ir, cond);
            e = base;
            if (gate == 1) e.ir_le = 1'b1;
            if (gate == 2) e.mdr_le = 1'b1;
            push(e, 1'b1, ir, cond);
            to = 1'b0;
        end
    endtask

    task automatic build_instr(input logic [31:0] ir, input logic cond,
                               input int wf, input int wm, output bit to);
        exp_t e;
        int   opc;
        to = 1'b0;
        e = dflt(4'd1); e.a = 2'b01; e.b = 2'b11; e.mar_le = 1'b1;
        push(e, 1'($urandom_range(0, 1)), ir, cond);
        e = dflt(4'd2); e.mfa = 1'b1;
        push_wait(e, wf, 1, ir, cond, to);
        if (to) return;
        e = dflt(4'd3); e.a = 2'b01; e.b = 2'b10; e.dst = 2'b10; e.rf_le = 1'b1;
        push(e, 1'($urandom_range(0, 1)), ir, cond);
        push(dflt(4'd4), 1'($urandom_range(0, 1)), ir, cond);
        if (!cond) return;
        case (ir[27:25])
            3'd0, 3'd1: begin
                opc = int'(ir[24:21]);
                e = dflt(4'd5); e.op = ir[24:21]; e.sr_le = ir[20];
                e.rf_le = !(opc >= 8 && opc <= 11);
                push(e, 1'($urandom_range(0, 1)), ir, cond);
            end
            3'd2, 3'd3: begin
                e = dflt(4'd6); e.mar_le = 1'b1; e.op = ir[23] ? 4'd4 : 4'd2;
                push(e, 1'($urandom_range(0, 1)), ir, cond);
                if (ir[20]) begin
                    e = dflt(4'd9); e.mfa = 1'b1;
                    push_wait(e, wm, 2, ir, cond, to);
                    if (to) return;
                    e = dflt(4'd10); e.a = 2'b11; e.b = 2'b01; e.rf_le = 1'b1;
                    push(e, 1'($urandom_range(0, 1)), ir, cond);
                end else begin
                    e = dflt(4'd7); e.msel = 1'b1; e.mdr_le = 1'b1;
                    push(e, 1'($urandom_range(0, 1)), ir, cond);
                    e = dflt(4'd8); e.mfa = 1'b1; e.rw = 1'b0;
                    push_wait(e, wm, 0, ir, cond, to);
                end
            end
            3'd5: begin
                if (ir[24]) begin
                    e = dflt(4'd11); e.a = 2'b01; e.b = 2'b11; e.dst = 2'b01; e.rf_le = 1'b1;
                    push(e, 1'($urandom_range(0, 1)), ir, cond);
                end
                e = dflt(4'd12); e.a = 2'b01; e.b = 2'b00; e.dst = 2'b10; e.rf_le = 1'b1;
                push(e, 1'($urandom_range(0, 1)), ir, cond);
            end
            default: ;
        endcase
    endtask

    task automatic run_queue();
        stim_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(posedge CLK);
            #1;
            bus.MOC  = s.moc;
            bus.IR   = s.ir;
            bus.COND = s.cond;
            @(negedge CLK);
            check_eq($sformatf("state(exp %0d)", s.e.st), 32'(bus.STATE), 32'(s.e.st));
            check_eq($sformatf("ctl(st %0d)", s.e.st), 32'(observed()), 32'(s.e));
        end
    endtask

    // Called just after a negedge: pulse CLR low mid-cycle, check, release before the edge.
    task automatic reset_pulse(input string tag);
        exp_t r;
        r = dflt(4'd0);
        r.op = 4'b0000;
        #2 CLR = 1'b0;
        #1;
        check_eq({tag, "_state"}, 32'(bus.STATE), 32'd0);
        check_eq({tag, "_ctl"}, 32'(observed()), 32'(r));
        #1 CLR = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          to;
        logic [31:0] ir;
        logic [2:0]  cls [8];
        exp_t        r;

        cls = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd4, 3'd7};
        bus.IR = 32'd0; bus.COND = 1'b0; bus.MOC = 1'b0;

        // Reset held from time zero.
        r = dflt(4'd0); r.op = 4'b0000;
        #3;
        check_eq("por_state", 32'(bus.STATE), 32'd0);
        check_eq("por_ctl", 32'(observed()), 32'(r));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_hold_ctl", 32'(observed()), 32'(r));
        #4 CLR = 1'b1;

        // Directed instructions.
        build_instr(32'hE0912003, 1'b1, 0, 0, to); run_queue();   // ADDS
        build_instr(32'hE1510002, 1'b1, 2, 0, to); run_queue();   // CMP
        build_instr(32'hE0912003, 1'b0, 1, 0, to); run_queue();   // COND fail
        build_instr(32'hE5912004, 1'b1, 0, 3, to); run_queue();   // LDR, 3 waits
        build_instr(32'hEB000010, 1'b1, 1, 0, to); run_queue();   // BL
        build_instr(32'hE5812004, 1'b1, 0, 2, to); run_queue();   // STR
        build_instr(32'hE0912003, 1'b1, TO - 1, 0, to); run_queue(); // MOC on last allowed cycle
        build_instr(32'hE5912004, 1'b1, 0, TO - 1, to); run_queue();

        // Reset mid-load with MFA asserted: keep only the first 3 LD_MEM wait cycles.
        build_instr(32'hE5912004, 1'b1, 0, 5, to);
        repeat (4) void'(q.pop_back());
        run_queue();
        reset_pulse("rst_ld_mem");

        // Fetch timeout, then recovery.
        build_instr(32'hE0912003, 1'b1, TO, 0, to); run_queue();
        reset_pulse("rst_err_f");

        // Store timeout, then recovery.
        build_instr(32'hE5812004, 1'b1, 1, TO, to); run_queue();
        reset_pulse("rst_err_s");

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            int wf;
            int wm;
            ir = $urandom;
            ir[27:25] = cls[$urandom_range(0, 7)];
            wf = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            build_instr(ir, 1'($urandom_range(0, 3) != 0), wf, wm, to);
            run_queue();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
